// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_mp register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Address width for a given depth; a 2-entry file still needs one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_mp.sv
// Register file with 2 combinational reads, 1 synchronous write, r0 = 0, and a sequenced clear.
// Build option: define REGFILE_BYPASS_EN for write-first read ports (default is read-first).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic [AW-1:0]    dbg_idx,
    output logic [WIDTH-1:0] dbg_data,
    output logic             ready
);

    state_t           r_state;
    state_t           w_next_state;
    logic [AW-1:0]    r_clr_cnt;
    logic [WIDTH-1:0] r_dbg;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_mem_we;
    logic [AW-1:0]    w_mem_wa;
    logic [WIDTH-1:0] w_mem_wd;
    logic             w_clr_last;
    logic             w_byp1;
    logic             w_byp2;

    assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (r_state == CLEAR) begin
            if (w_clr_last) begin
                w_next_state = RUN;
            end
        end else if (clr_req) begin
            w_next_state = CLEAR;
        end
    end

    // Output / array-port logic; the array has a single write port so it can map to RAM
    always_comb begin
        ready    = (r_state == RUN);
        w_mem_we = 1'b0;
        w_mem_wa = r_clr_cnt;
        w_mem_wd = '0;
        if (!rst) begin
            if (r_state == CLEAR) begin
                w_mem_we = 1'b1;
            end else if (we3 && (wa3 != '0)) begin
                w_mem_we = 1'b1;
                w_mem_wa = wa3;
                w_mem_wd = wd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
            r_dbg     <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + AW'(1);
            end else if (clr_req) begin
                r_clr_cnt <= '0;
            end
            r_dbg <= ((r_state == RUN) && (dbg_idx != '0)) ? r_mem[dbg_idx] : '0;
        end
    end

    assign dbg_data = r_dbg;

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = (r_state == RUN) && we3 && (wa3 == ra1);
    assign w_byp2 = (r_state == RUN) && we3 && (wa3 == ra2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if ((r_state == RUN) && (ra1 != '0)) begin
            rd1 = w_byp1 ? wd3 : r_mem[ra1];
        end
        if ((r_state == RUN) && (ra2 != '0)) begin
            rd2 = w_byp2 ? wd3 : r_mem[ra2];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DEPTH=8, WIDTH=8): directed scenarios then random traffic
// against an array-level reference model.
module tb_regfile_mp;

    localparam int W = 8;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr_req = 1'b0;
    logic         we3 = 1'b0;
    logic [A-1:0] wa3 = '0;
    logic [W-1:0] wd3 = '0;
    logic [A-1:0] ra1 = '0;
    logic [A-1:0] ra2 = '0;
    logic [A-1:0] dbg_idx = '0;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] dbg_data;
    logic         ready;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .ready    (ready)
    );

    typedef struct {
        logic         rdy;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W-1:0] dbg;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: register contents, clear cycles remaining, debug register
    logic [W-1:0] m [D];
    int           clear_left = 0;
    logic [W-1:0] m_dbg = '0;
    bit           model_valid = 1'b0;

    function automatic logic [W-1:0] model_read(input logic [A-1:0] ra);
        if (clear_left != 0 || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && wa3 == ra) return wd3;
`endif
        return m[ra];
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (ready !== e.rdy || rd1 !== e.r1 || rd2 !== e.r2 || dbg_data !== e.dbg) begin
                n_err++;
                $display("FAIL %s @%0t: got ready=%0b rd1=%h rd2=%h dbg=%h, expected ready=%0b rd1=%h rd2=%h dbg=%h",
                         nm, $time, ready, rd1, rd2, dbg_data, e.rdy, e.r1, e.r2, e.dbg);
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit w, input int wa, input int wd,
                        input int a1, input int a2, input int di, input string nm);
        exp_t e;
        rst     = r;
        clr_req = c;
        we3     = w;
        wa3     = A'(wa);
        wd3     = W'(wd);
        ra1     = A'(a1);
        ra2     = A'(a2);
        dbg_idx = A'(di);
        if (model_valid) begin
            e.rdy = (clear_left == 0);
            e.r1  = model_read(ra1);
            e.r2  = model_read(ra2);
            e.dbg = m_dbg;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        if (r) begin
            clear_left  = D;
            m_dbg       = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (clear_left > 0) begin
                clear_left--;
                m_dbg = '0;
                if (clear_left == 0) begin
                    for (int i = 0; i < D; i++) m[i] = '0;
                end
            end else begin
                m_dbg = (dbg_idx == 0) ? '0 : m[dbg_idx];
                if (w && wa3 != 0) m[wa3] = wd3;
                if (c) clear_left = D;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, $urandom_range(0, D-1), $urandom_range(0, D-1),
                 $urandom_range(0, D-1), nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 3, 4, 5, "reset");
        step(0, 0, 0, 0, 0, 1, 2, 3, "clear");
        step(0, 0, 1, 2, 8'h55, 2, 2, 2, "clear_write_r2");
        idle(8, "clear_to_ready");

        step(0, 0, 1, 3, 8'hA5, 0, 0, 0, "write_r3");
        step(0, 0, 1, 7, 8'h3C, 0, 0, 0, "write_r7");
        step(0, 0, 0, 0, 0, 3, 7, 7, "read_r3_r7");
        step(0, 0, 0, 0, 0, 3, 7, 7, "dbg_r7");
        step(0, 0, 1, 0, 8'hFF, 0, 0, 0, "write_r0");
        step(0, 0, 0, 0, 0, 0, 2, 0, "read_r0_r2");
        step(0, 0, 0, 0, 0, 2, 0, 2, "read_r2");

        step(0, 0, 1, 5, 8'h22, 0, 0, 0, "write_r5");
        step(0, 0, 1, 5, 8'h11, 5, 5, 5, "bypass_r5");
        step(0, 0, 0, 0, 0, 5, 3, 5, "after_bypass");
        step(0, 0, 0, 0, 0, 5, 3, 5, "after_bypass_dbg");

        for (int i = 1; i < D; i++) step(0, 0, 1, i, $urandom_range(1, 255), 0, 0, 0, "fill");
        step(0, 1, 1, 4, 8'h77, 1, 4, 4, "clr_req");
        idle(9, "clr_req_clear");
        for (int i = 0; i < D; i++) step(0, 0, 0, 0, 0, i, D-1-i, i, "post_clear_read");

        step(1, 0, 0, 0, 0, 0, 0, 0, "reset2");
        idle(4, "partial_clear");
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset_mid_clear");
        idle(10, "restart_clear");

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, D-1), $urandom_range(0, 255),
                 $urandom_range(0, D-1), $urandom_range(0, D-1), $urandom_range(0, D-1), "random");

        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised general-purpose register file for the single-cycle datapath: WIDTH-bit, DEPTH-entry, two combinational read ports, one synchronous write port, and register 0 hardwired to zero. It replaces the per-register flop reset with a sequenced clear FSM, so the array can map to distributed RAM. A registered debug read port replaces the fixed eight register taps feeding the display logic.

## Interface
- WIDTH, 8, data width in bits (1..64)
- DEPTH, 32, number of registers; power of two, 2..32
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  request a full clear while running (one-cycle pulse suffices)
- we3  in  1  write enable
- wa3  in  AW  write address
- wd3  in  WIDTH  write data
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  WIDTH  read data, port 1 (combinational)
- rd2  out  WIDTH  read data, port 2 (combinational)
- dbg_idx  in  AW  debug read address
- dbg_data  out  WIDTH  debug read data, registered
- ready  out  1  high when in RUN; writes accepted only when high

## Operation
- FSM states: CLEAR, RUN. Encoding comes from the package enum.
- rst sampled high: state <= CLEAR, clr_cnt <= 0, dbg_data <= 0. Array contents are not touched on that edge.
- CLEAR: each edge with rst low writes mem[clr_cnt] <= 0 and increments clr_cnt. On the edge that clears index DEPTH-1, state <= RUN. clr_cnt wraps to 0 and is not used in RUN.
- CLEAR: ready=0, rd1=rd2=0, we3 ignored, clr_req ignored (no restart).
- RUN: ready=1. Edge with we3=1 and wa3!=0 writes mem[wa3] <= wd3. A write to wa3=0 is dropped.
- RUN with clr_req=1: state <= CLEAR, clr_cnt <= 0. A write presented on that same edge is still performed and is then overwritten by the clear.
- Reads: an address of 0 returns 0 on rd1, rd2 and dbg_data regardless of array content.
- Read-during-write to the same nonzero address: behaviour is set by the bypass option (see Configuration).
- dbg_data <= (state==RUN) ? mem[dbg_idx] : 0 on every edge. It always reflects pre-write array contents and is never bypassed.
- rst high mid-CLEAR restarts the clear from index 0. rst high during RUN returns to CLEAR.

## Timing
- Reset values: ready=0, dbg_data=0, rd1=rd2=0 (state CLEAR).
- Clear latency: ready rises exactly DEPTH edges after the first edge with rst low (DEPTH=8: 8 cycles).
- Write latency: 1 edge. The written value is visible on rd1/rd2 in the following cycle.
- dbg_data latency: 1 edge from dbg_idx.
- Read ports have no clock latency. They are purely combinational from ra1/ra2, state and the array.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, with we3=1, wa3==raN and wa3!=0, rdN = wd3 combinationally (write-first).
- REGFILE_BYPASS_EN undefined:
  - rdN returns the stored (old) value until the edge (read-first).
- dbg_data is unaffected by the macro in both builds.

## Structure
- Package regfile_pkg holds:
  - the state_t enum {CLEAR, RUN}
  - the localparam function computing AW
- No sub-module. Clear FSM, array, bypass mux and debug register live in regfile_mp.

## Test plan
- Reset: DEPTH=8, WIDTH=8. Hold rst 2 cycles, then release → ready=0 for 8 cycles then 1; rd1=rd2=dbg_data=0 throughout.
- Write/read: after ready, write 0xA5 to r3 and 0x3C to r7, then set ra1=3, ra2=7 → rd1=0xA5, rd2=0x3C. Set dbg_idx=7 → dbg_data=0x3C one cycle later.
- r0: write 0xFF to wa3=0, then ra1=0 → rd1=0. Write during CLEAR to r2 → r2 reads 0 after ready.
- Bypass: same cycle we3=1, wa3=5, wd3=0x11, ra1=5 while r5=0x22 → rd1=0x11 with REGFILE_BYPASS_EN, rd1=0x22 without; both builds read 0x11 next cycle.
- clr_req: with r1..r7 nonzero, pulse clr_req → ready=0 next cycle for 8 cycles; afterwards all reads return 0.
- Reset mid-clear: assert rst at clear index 4 → clear restarts; ready rises 8 cycles after rst release.
